c2h_read_packetizer: RTL and testbench
======================================

Name: c2h_read_packetizer

Overview:
- Sits directly downstream of the SDDT core's C2H read-data stream (M_AXIS_C2H_*), between the core and the DMA S2MM channel.
- Buffers 512-bit read beats in a small FIFO and groups them into DMA packets of a runtime-programmable length, asserting tlast on the final beat of each packet.
- Closes a partial packet with tlast after a programmable idle timeout, so host transfers complete even when the instruction stream ends mid-packet.

Parameters:
- DATA_WIDTH, 512, tdata width; tkeep is DATA_WIDTH/8.
- FIFO_DEPTH, 16, buffer entries; power of two, minimum 4.
- CNT_WIDTH, 16, width of pkt_beats, beat counter and idle timer.

Ports:
- clk  in  1  c0_ddr4 user clock.
- rst  in  1  synchronous, active-high reset.
- pkt_beats  in  CNT_WIDTH  beats per packet; 0 is treated as 1.
- idle_timeout  in  CNT_WIDTH  idle cycles before a partial packet is flushed; 0 disables flushing.
- s_axis_tdata  in  DATA_WIDTH  read data from the core.
- s_axis_tkeep  in  DATA_WIDTH/8  byte enables from the core.
- s_axis_tlast  in  1  upstream end marker; forces packet end.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  not full and not in reset.
- m_axis_tdata  out  DATA_WIDTH  to DMA S2MM.
- m_axis_tkeep  out  DATA_WIDTH/8  to DMA S2MM.
- m_axis_tlast  out  1  packet end.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  DMA ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: FIFO empty, fifo_level=0, beat_cnt=0, idle_cnt=0, state=IDLE. m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0. s_axis_tready=0 while rst=1.
- Reset mid-operation: all buffered beats are discarded; the partial packet is abandoned with no tlast.
- Input side:
  - Accept on s_tvalid & s_tready; s_tready = (fifo_level < FIFO_DEPTH) & !rst.
  - Each entry stores {tdata, tkeep, tlast}.
  - A simultaneous push and pop at full is not permitted, because tready is low at full. At any other level, simultaneous push and pop leaves fifo_level unchanged.
- Packet length:
  - len_q is latched from pkt_beats (0→1) when a beat is popped with beat_cnt==0.
  - The first beat of a packet compares against the incoming pkt_beats value directly.
  - Changing pkt_beats mid-packet has no effect until the next packet starts.
- Head is final when any of the following hold:
  - beat_cnt == len-1;
  - the stored tlast is 1;
  - state == FLUSH.
- Presentation rule (the head is held back until its tlast value is certain):
  - m_tvalid = (fifo_level ≥ 2) | (fifo_level == 1 & head_final).
  - m_tdata/m_tkeep come from the head entry; m_tlast = head_final.
  - Once asserted, m_tvalid and m_tlast hold stable until the handshake (AXI rule).
- Pop on m_tvalid & m_tready:
  - beat_cnt increments; it returns to 0 when the popped beat had m_tlast=1.
- Latency:
  - A beat accepted in cycle N is visible at the earliest in N+1 if it is final.
  - Otherwise it appears when the next beat arrives, or when the idle flush fires.
- State machine:
  - IDLE: beat_cnt==0 and the FIFO is empty. Go to IN_PKT on the first push.
  - IN_PKT:
    - idle_cnt counts cycles where fifo_level==1, the head is not final, and no push occurs.
    - idle_cnt clears on any push.
    - When idle_timeout≠0 and idle_cnt reaches idle_timeout-1, go to FLUSH.
    - Return to IDLE when the FIFO empties after a tlast pop.
  - FLUSH: the head is presented with tlast=1. On pop, beat_cnt=0, idle_cnt=0, and the state goes to IN_PKT if the FIFO is non-empty, else IDLE. A push during FLUSH does not change the head's tlast.
- Counter widths:
  - beat_cnt and idle_cnt are CNT_WIDTH bits and saturate, never wrap.
  - With idle_timeout=0 a partial packet waits indefinitely.

Optional Feature:
- Macro C2H_PKT_STATS_EN.
- When defined, adds two outputs; both reset to 0 and wrap on overflow:
  - pkt_count (32 bits): increments on every tlast pop.
  - flush_count (16 bits): increments on every pop made in FLUSH.
- When undefined, neither port nor its logic exists.

Test Plan:
- pkt_beats=4, idle_timeout=0, 8 back-to-back beats D0..D7, tready=1 → 8 output beats in order; tlast on D3 and D7 only; fifo_level ends at 0.
- pkt_beats=4, idle_timeout=10, 2 beats then input idle → D0 output immediately; D1 output with tlast=1 exactly 10 cycles after its push; state returns to IDLE; flush_count=1 when the macro is defined.
- pkt_beats=8, 3 beats with the third carrying s_tlast=1 → tlast on the third beat; the next beat starts a new packet (beat_cnt=0).
- tready held 0, 20 beats offered, FIFO_DEPTH=16 → 16 accepted, s_tready=0, fifo_level=16. Release tready → all 16 emerge in order with tvalid/tlast stable across the stalls.
- pkt_beats changed 4→2 after 1 beat of a packet → the current packet still ends after 4 beats; the following packets are 2 beats.
- rst asserted for 1 cycle with 5 beats buffered → next cycle m_tvalid=0, fifo_level=0; a fresh 4-beat stream produces tlast on its 4th beat.

Source files
------------

// File: rtl/c2h_read_packetizer.sv
// Buffers C2H read beats and regroups them into DMA packets of pkt_beats beats, closing idle partial packets.
// Optional stats counters (pkt_count, flush_count) are built when C2H_PKT_STATS_EN is defined.
module c2h_read_packetizer #(
    parameter int DATA_WIDTH = 512,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CNT_WIDTH-1:0]            pkt_beats,
    input  logic [CNT_WIDTH-1:0]            idle_timeout,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]         s_axis_tkeep,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
`ifdef C2H_PKT_STATS_EN
    ,
    output logic [31:0]                     pkt_count,
    output logic [15:0]                     flush_count
`endif
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;
    localparam logic [LW-1:0]        DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_W-1:0]     keep;
        logic                  last;
    } entry_t;

    typedef enum logic [1:0] {IDLE, IN_PKT, FLUSH} state_t;

    entry_t               mem [FIFO_DEPTH];
    entry_t               head;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level, level_nxt;
    logic [CNT_WIDTH-1:0] beat_cnt, len_q, len_cur, idle_cnt;
    state_t               state, state_nxt;
    logic                 push, pop, base_final, idle_cond, flush_fire, head_final;

    assign fifo_level    = level;
    assign s_axis_tready = (level < DEPTH_L) & ~rst;
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign level_nxt     = level + LW'(push) - LW'(pop);
    assign head          = mem[rd_ptr];

    // First beat of a packet uses the live pkt_beats; later beats use the latched length.
    always_comb begin
        len_cur = len_q;
        if (beat_cnt == '0)
            len_cur = (pkt_beats == '0) ? CNT_ONE : pkt_beats;
    end

    assign base_final = (beat_cnt == len_cur - CNT_ONE) | head.last | (state == FLUSH);
    assign idle_cond  = (state == IN_PKT) & (level == LW'(1)) & ~base_final;
    // Timeout closes the head in the same cycle it expires; FLUSH then holds tlast until the pop.
    assign flush_fire = idle_cond & (idle_timeout != '0) & (idle_cnt == idle_timeout - CNT_ONE);
    assign head_final = base_final | flush_fire;

    assign m_axis_tvalid = (level >= LW'(2)) | ((level == LW'(1)) & head_final);
    assign m_axis_tlast  = m_axis_tvalid & head_final;
    assign m_axis_tdata  = m_axis_tvalid ? head.data : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? head.keep : '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            beat_cnt <= '0;
            len_q    <= CNT_ONE;
            idle_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            if (pop) begin
                if (beat_cnt == '0)
                    len_q <= len_cur;
                if (m_axis_tlast)
                    beat_cnt <= '0;
                else if (beat_cnt != CNT_MAX)
                    beat_cnt <= beat_cnt + CNT_ONE;
            end
            if (push | ~idle_cond)
                idle_cnt <= '0;
            else if (idle_cnt != CNT_MAX)
                idle_cnt <= idle_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (push)
                    state_nxt = IN_PKT;
            end
            IN_PKT: begin
                if (pop & m_axis_tlast & (level_nxt == '0))
                    state_nxt = IDLE;
                else if (flush_fire & ~pop)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                if (pop)
                    state_nxt = (level_nxt != '0) ? IN_PKT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef C2H_PKT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count   <= '0;
            flush_count <= '0;
        end else begin
            if (pop & m_axis_tlast)
                pkt_count <= pkt_count + 32'd1;
            if (pop & ((state == FLUSH) | flush_fire))
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_c2h_read_packetizer.sv
// Directed and randomized checks of c2h_read_packetizer against a packet-level scoreboard.
module tb_c2h_read_packetizer;
    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int DEPTH = 16;
    localparam int CW = 16;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] pkt_beats, idle_timeout;
    logic [DW-1:0] s_tdata, m_tdata;
    logic [KW-1:0] s_tkeep, m_tkeep;
    logic          s_tlast, s_tvalid, s_tready, m_tlast, m_tvalid, m_tready;
    logic [LW-1:0] fifo_level;
`ifdef C2H_PKT_STATS_EN
    logic [31:0]   pkt_count;
    logic [15:0]   flush_count;
`endif

    c2h_read_packetizer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .pkt_beats(pkt_beats), .idle_timeout(idle_timeout),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .fifo_level(fifo_level)
`ifdef C2H_PKT_STATS_EN
        , .pkt_count(pkt_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    int            total = 0, bad = 0;
    int            mpos = 0, mlen = 1, pops = 0, tlasts = 0;
    bit            pushed = 0, prev_stall = 0;
    beat_t         prev_beat;
    logic          smp_valid, smp_last;
    logic [DW-1:0] smp_data;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Packet framing from the rules: a beat ends its packet at position len-1 or on upstream tlast.
    task automatic model_push(input beat_t b);
        beat_t e;
        if (mpos == 0) mlen = (pkt_beats == '0) ? 1 : int'(pkt_beats);
        e = b;
        e.l = b.l | (mpos == mlen - 1);
        mpos = e.l ? 0 : mpos + 1;
        exp_q.push_back(e);
    endtask

    task automatic rand_beat();
        for (int w = 0; w < DW / 32; w++) s_tdata[w*32 +: 32] = $urandom;
        s_tkeep = {$urandom, $urandom};
        s_tlast = 1'b0;
    endtask

    // One clock: sample at negedge (inputs are stable), score handshakes, then step past posedge.
    task automatic cycle();
        beat_t o, e;
        @(negedge clk);
        smp_valid = m_tvalid;
        smp_last  = m_tlast;
        smp_data  = m_tdata;
        pushed = 0;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", DW'(m_tvalid), DW'(1));
                chk("hold_last", DW'(m_tlast), DW'(prev_beat.l));
                chk("hold_data", m_tdata, prev_beat.d);
            end
            o = beat_t'{d: m_tdata, k: m_tkeep, l: m_tlast};
            if (m_tvalid && m_tready) begin
                pops++;
                if (m_tlast) tlasts++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL unexpected_pop: got %0h want none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", o.d, e.d);
                    chk("out_keep", DW'(o.k), DW'(e.k));
                    chk("out_last", DW'(o.l), DW'(e.l));
                end
            end
            prev_stall = m_tvalid & ~m_tready;
            prev_beat  = o;
            if (s_tvalid && s_tready) begin
                pushed = 1;
                model_push(beat_t'{d: s_tdata, k: s_tkeep, l: s_tlast});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit rnd_ready);
        s_tvalid = 1'b0;
        for (int j = 0; j < 600; j++) begin
            if (exp_q.size() == 0) break;
            m_tready = rnd_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
            cycle();
        end
        m_tready = 1'b1;
        cycle();
        chk("drain_empty", DW'(exp_q.size()), '0);
        chk("drain_level", DW'(fifo_level), '0);
    endtask

    task automatic send(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            rand_beat();
            s_tlast  = (i == last_at);
            s_tvalid = 1'b1;
            for (int t = 0; t < 50; t++) begin
                cycle();
                if (pushed) break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic rand_phase(input int plen, input int ncyc);
        pkt_beats = CW'(plen);
        idle_timeout = '0;
        s_tvalid = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            if (!s_tvalid || pushed) begin
                s_tvalid = ($urandom_range(0, 9) < 7);
                rand_beat();
                s_tlast = ($urandom_range(0, 7) == 0);
            end
            m_tready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        rand_beat();
        s_tlast = 1'b1;
        s_tvalid = 1'b1;
        for (int j = 0; j < 100; j++) begin
            m_tready = ($urandom_range(0, 9) < 7);
            cycle();
            if (pushed) break;
        end
        chk("close_accepted", DW'(pushed), DW'(1));
        drain(1'b1);
    endtask

    initial begin
        int p0, t0, acc, first;
        logic [DW-1:0] d1;
        beat_t fix;
`ifdef C2H_PKT_STATS_EN
        logic [15:0] fc0;
`endif
        rst = 1'b1; pkt_beats = CW'(4); idle_timeout = '0;
        s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", DW'(s_tready), '0);
        chk("rst_m_tvalid", DW'(m_tvalid), '0);
        chk("rst_m_tlast", DW'(m_tlast), '0);
        chk("rst_m_tdata", m_tdata, '0);
        chk("rst_m_tkeep", DW'(m_tkeep), '0);
        chk("rst_level", DW'(fifo_level), '0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_tready", DW'(s_tready), DW'(1));

        // 8 back-to-back beats, packets of 4
        m_tready = 1'b1; p0 = pops; t0 = tlasts;
        send(8, -1);
        drain(1'b0);
        chk("t1_pops", DW'(pops - p0), DW'(8));
        chk("t1_tlasts", DW'(tlasts - t0), DW'(2));

        // idle flush closes a 2-beat partial packet
        idle_timeout = CW'(10);
`ifdef C2H_PKT_STATS_EN
        fc0 = flush_count;
`endif
        rand_beat(); s_tvalid = 1'b1; cycle();
        rand_beat(); d1 = s_tdata; cycle();
        s_tvalid = 1'b0;
        fix = exp_q.pop_back(); fix.l = 1'b1; exp_q.push_back(fix); mpos = 0;
        first = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (first < 0 && smp_valid && smp_data == d1) begin
                first = i;
                chk("t2_flush_last", DW'(smp_last), DW'(1));
            end
        end
        chk("t2_flush_delay", DW'(first), DW'(10));
        chk("t2_level", DW'(fifo_level), '0);
        chk("t2_idle_valid", DW'(m_tvalid), '0);
`ifdef C2H_PKT_STATS_EN
        chk("t2_flush_count", DW'(flush_count), DW'(fc0 + 16'd1));
`endif
        idle_timeout = '0;
        t0 = tlasts;
        send(4, -1);
        drain(1'b0);
        chk("t2_fresh_pkt", DW'(tlasts - t0), DW'(1));

        // upstream tlast ends a packet early
        pkt_beats = CW'(8); t0 = tlasts;
        send(3, 2);
        drain(1'b0);
        chk("t3_early_tlast", DW'(tlasts - t0), DW'(1));
        send(8, -1);
        drain(1'b0);
        chk("t3_next_pkt", DW'(tlasts - t0), DW'(2));

        // fill to full with output stalled, then drain with random stalls
        pkt_beats = CW'(4); m_tready = 1'b0; acc = 0; p0 = pops;
        rand_beat(); s_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (pushed) begin acc++; rand_beat(); end
        end
        chk("t4_accepted", DW'(acc), DW'(16));
        chk("t4_s_tready", DW'(s_tready), '0);
        chk("t4_level", DW'(fifo_level), DW'(16));
        drain(1'b1);
        chk("t4_pops", DW'(pops - p0), DW'(16));

        // pkt_beats change mid-packet only affects later packets
        pkt_beats = CW'(4); t0 = tlasts;
        send(2, -1);
        cycle();
        pkt_beats = CW'(2);
        send(6, -1);
        drain(1'b0);
        chk("t5_tlasts", DW'(tlasts - t0), DW'(3));

        // reset with beats buffered
        m_tready = 1'b0;
        send(5, -1);
        chk("t6_level5", DW'(fifo_level), DW'(5));
        rst = 1'b1;
        #1;
        chk("t6_rst_s_tready", DW'(s_tready), '0);
        cycle();
        rst = 1'b0;
        exp_q.delete(); mpos = 0;
        chk("t6_m_tvalid", DW'(m_tvalid), '0);
        chk("t6_level", DW'(fifo_level), '0);
        m_tready = 1'b1; pkt_beats = CW'(4); t0 = tlasts;
        send(4, -1);
        drain(1'b0);
        chk("t6_fresh_tlast", DW'(tlasts - t0), DW'(1));

        // randomized traffic, including pkt_beats=0 (treated as 1)
        rand_phase(3, 80);
        rand_phase(0, 40);
        rand_phase(5, 120);
        rand_phase(1, 40);
        rand_phase(2, 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
